// File: rtl/data_memory_fabric.sv
// Data-side memory fabric: address decode into a data RAM, a stack RAM and a
// serial MMIO window. Registered 1-cycle responses with fault reporting,
// little-endian byte/half lanes, and TX/RX byte FIFOs toward the serial link.
module data_memory_fabric #(
   parameter logic [15:0] DATA_BASE   = 16'h1000,
   parameter logic [15:0] STACK_BASE  = 16'h7fff,
   parameter logic [15:0] SERIAL_BASE = 16'hffff,
   parameter int          MEM_WORDS   = 1024,
   parameter int          FIFO_DEPTH  = 4,
   parameter string       INIT_FILE   = "test/data_ram.memh"
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] addr_in,
   input  logic [31:0] writedata_in,
   input  logic        re_in,
   input  logic        we_in,
   input  logic [1:0]  size_in,
   output logic [31:0] readdata_out,
   output logic        resp_valid_out,
   output logic        fault_out,
   input  logic [7:0]  serial_in,
   input  logic        serial_valid_in,
   output logic        serial_rden_out,
   output logic [7:0]  serial_out,
   input  logic        serial_ready_in,
   output logic        serial_wren_out
);

   localparam int          AW          = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int          PW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int          CW          = PW + 1;
   localparam logic [31:0] MEM_WORDS_U = MEM_WORDS;
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

   // storage
   logic [31:0] r_dmem [MEM_WORDS];
   logic [31:0] r_smem [MEM_WORDS];
   logic [31:0] r_dq, r_sq;

   // FIFO state
   logic [7:0]    r_tx_mem [FIFO_DEPTH];
   logic [7:0]    r_rx_mem [FIFO_DEPTH];
   logic [PW-1:0] r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
   logic [CW-1:0] r_tx_cnt, r_rx_cnt;

   // response state
   logic        r_valid, r_fault;
   logic [1:0]  r_src;   // 0 none, 1 data RAM, 2 stack RAM, 3 serial word
   logic [1:0]  r_size;
   logic [1:0]  r_off;
   logic [31:0] r_sword;

   // decode wires
   logic [15:0]   w_page, w_off;
   logic [AW-1:0] w_idx;
   logic          w_sel_d, w_sel_s, w_sel_ser, w_sel_ram;
   logic          w_req, w_both, w_size_bad, w_misal, w_oob;
   logic          w_off_rx, w_off_st, w_off_tx, w_ser_bad;
   logic          w_fault, w_ok, w_dmem_we, w_smem_we;
   logic          w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
   logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
   logic [3:0]    w_be;
   logic [31:0]   w_wdat, w_status, w_word, w_shift, w_rdata;

   assign w_page    = addr_in[31:16];
   assign w_off     = addr_in[15:0];
   assign w_idx     = addr_in[AW+1:2];
   assign w_sel_d   = (w_page == DATA_BASE);
   assign w_sel_s   = (w_page == STACK_BASE);
   assign w_sel_ser = (w_page == SERIAL_BASE);
   assign w_sel_ram = w_sel_d | w_sel_s;

   assign w_tx_full  = (r_tx_cnt == DEPTH_C);
   assign w_tx_empty = (r_tx_cnt == '0);
   assign w_rx_full  = (r_rx_cnt == DEPTH_C);
   assign w_rx_empty = (r_rx_cnt == '0);

   assign w_req      = re_in | we_in;
   assign w_both     = re_in & we_in;
   assign w_size_bad = (size_in == 2'd3);
   assign w_misal    = ((size_in == 2'd1) & addr_in[0]) |
                       ((size_in == 2'd2) & (addr_in[1:0] != 2'b00));
   assign w_oob      = ({18'b0, addr_in[15:2]} >= MEM_WORDS_U);

   // serial window only accepts exact offsets in the right direction
   assign w_off_rx  = (w_off == 16'h0000);
   assign w_off_st  = (w_off == 16'h0004);
   assign w_off_tx  = (w_off == 16'h0008);
   assign w_ser_bad = !((w_off_rx & re_in & !w_rx_empty) |
                        (w_off_st & re_in) |
                        (w_off_tx & we_in & !w_tx_full));

   assign w_fault = w_req & (w_both | w_size_bad | !(w_sel_ram | w_sel_ser) |
                             (w_sel_ram & (w_misal | w_oob)) |
                             (w_sel_ser & w_ser_bad));
   assign w_ok    = w_req & !w_fault;

   assign w_dmem_we = w_ok & we_in & w_sel_d;
   assign w_smem_we = w_ok & we_in & w_sel_s;
   assign w_tx_push = w_ok & we_in & w_sel_ser & w_off_tx;
   assign w_rx_pop  = w_ok & re_in & w_sel_ser & w_off_rx;

   // link side: drain when the link is ready, fill when room; quiet in reset
   assign w_tx_pop        = !w_tx_empty & serial_ready_in;
   assign w_rx_push       = serial_valid_in & !w_rx_full & reset;
   assign serial_wren_out = w_tx_pop;
   assign serial_rden_out = w_rx_push;
   assign serial_out      = r_tx_mem[r_tx_rd];

   assign w_status = {16'h0, 8'(r_rx_cnt), 6'(r_tx_cnt), w_tx_full, w_rx_empty};

   // store lane enables and right-aligned data replicated onto every lane
   always_comb begin
      w_be   = 4'b0000;
      w_wdat = writedata_in;
      case (size_in)
         2'd0: begin
            w_be   = 4'b0001 << addr_in[1:0];
            w_wdat = {4{writedata_in[7:0]}};
         end
         2'd1: begin
            w_be   = addr_in[1] ? 4'b1100 : 4'b0011;
            w_wdat = {2{writedata_in[15:0]}};
         end
         2'd2: w_be = 4'b1111;
         default: w_be = 4'b0000;
      endcase
   end

   // RAM arrays: lane-masked writes and a registered read of the addressed word
   always_ff @(posedge clock) begin
      for (int l = 0; l < 4; l++) begin
         if (w_dmem_we && w_be[l]) r_dmem[w_idx][8*l +: 8] <= w_wdat[8*l +: 8];
         if (w_smem_we && w_be[l]) r_smem[w_idx][8*l +: 8] <= w_wdat[8*l +: 8];
      end
      r_dq <= r_dmem[w_idx];
      r_sq <= r_smem[w_idx];
   end

   // response register: strobe, fault and which source feeds readdata
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_valid <= 1'b0;
         r_fault <= 1'b0;
         r_src   <= 2'd0;
         r_size  <= 2'd2;
         r_off   <= 2'd0;
         r_sword <= 32'h0;
      end else begin
         r_valid <= w_req;
         r_fault <= w_fault;
         r_src   <= 2'd0;
         r_size  <= 2'd2;
         r_off   <= 2'd0;
         r_sword <= w_rx_pop ? {24'h0, r_rx_mem[r_rx_rd]} : w_status;
         if (w_ok && re_in) begin
            if (w_sel_ser) begin
               r_src <= 2'd3;
            end else begin
               r_src  <= w_sel_d ? 2'd1 : 2'd2;
               r_size <= size_in;
               r_off  <= addr_in[1:0];
            end
         end
      end
   end

   // TX FIFO: CPU pushes, link drains
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_tx_wr  <= '0;
         r_tx_rd  <= '0;
         r_tx_cnt <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_tx_mem[i] <= 8'h0;
      end else begin
         if (w_tx_push) begin
            r_tx_mem[r_tx_wr] <= writedata_in[7:0];
            r_tx_wr           <= r_tx_wr + PW'(1);
         end
         if (w_tx_pop) r_tx_rd <= r_tx_rd + PW'(1);
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1);
            2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1);
            default: r_tx_cnt <= r_tx_cnt;
         endcase
      end
   end

   // RX FIFO: link fills, CPU pops
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rx_wr  <= '0;
         r_rx_rd  <= '0;
         r_rx_cnt <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_rx_mem[i] <= 8'h0;
      end else begin
         if (w_rx_push) begin
            r_rx_mem[r_rx_wr] <= serial_in;
            r_rx_wr           <= r_rx_wr + PW'(1);
         end
         if (w_rx_pop) r_rx_rd <= r_rx_rd + PW'(1);
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1);
            2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1);
            default: r_rx_cnt <= r_rx_cnt;
         endcase
      end
   end

   // load result: shift the selected lane down and zero-extend
   always_comb begin
      w_word = 32'h0;
      case (r_src)
         2'd1:    w_word = r_dq;
         2'd2:    w_word = r_sq;
         2'd3:    w_word = r_sword;
         default: w_word = 32'h0;
      endcase
      w_shift = w_word >> {r_off, 3'b000};
      case (r_size)
         2'd0:    w_rdata = {24'h0, w_shift[7:0]};
         2'd1:    w_rdata = {16'h0, w_shift[15:0]};
         default: w_rdata = w_shift;
      endcase
   end

   assign readdata_out   = w_rdata;
   assign resp_valid_out = r_valid;
   assign fault_out      = r_fault;

endmodule

// File: tb/tb_data_memory_fabric.sv
// Scoreboard bench for data_memory_fabric: expected responses are queued when
// a request is driven and compared when the response strobe appears.
module tb_data_memory_fabric;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] addr_in = 32'h0;
   logic [31:0] writedata_in = 32'h0;
   logic        re_in = 1'b0;
   logic        we_in = 1'b0;
   logic [1:0]  size_in = 2'd2;
   logic [31:0] readdata_out;
   logic        resp_valid_out, fault_out;
   logic [7:0]  serial_in = 8'h0;
   logic        serial_valid_in = 1'b0;
   logic        serial_rden_out;
   logic [7:0]  serial_out;
   logic        serial_ready_in = 1'b0;
   logic        serial_wren_out;

   typedef struct {
      logic        fault;
      logic [31:0] data;
      string       tag;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   localparam logic [31:0] ST = 32'hFFFF_0004;

   data_memory_fabric #(
      .MEM_WORDS (1024),
      .FIFO_DEPTH(4),
      .INIT_FILE ("")
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .addr_in        (addr_in),
      .writedata_in   (writedata_in),
      .re_in          (re_in),
      .we_in          (we_in),
      .size_in        (size_in),
      .readdata_out   (readdata_out),
      .resp_valid_out (resp_valid_out),
      .fault_out      (fault_out),
      .serial_in      (serial_in),
      .serial_valid_in(serial_valid_in),
      .serial_rden_out(serial_rden_out),
      .serial_out     (serial_out),
      .serial_ready_in(serial_ready_in),
      .serial_wren_out(serial_wren_out)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, expv);
      end
   endtask

   // drive one request at the falling edge and queue its expected response
   task automatic req(input logic r, input logic w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic ef, input logic [31:0] ed, input string tag);
      exp_t e;
      @(negedge clock);
      re_in = r; we_in = w; size_in = sz; addr_in = a; writedata_in = wd;
      e.fault = ef; e.data = ed; e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      @(negedge clock);
      re_in = 1'b0; we_in = 1'b0;
   endtask

   // response monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (resp_valid_out) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_strobe", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk({e.tag, "_fault"}, {31'b0, fault_out}, {31'b0, e.fault});
               chk({e.tag, "_data"}, readdata_out, e.data);
            end
         end
      end
   end

   // run-time bound
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      // reset state, with link inputs active to confirm handshakes stay quiet
      serial_valid_in = 1'b1; serial_ready_in = 1'b1; serial_in = 8'h5A;
      repeat (3) @(negedge clock);
      #1;
      chk("rst_readdata", readdata_out, 32'h0);
      chk("rst_valid", {31'b0, resp_valid_out}, 32'h0);
      chk("rst_fault", {31'b0, fault_out}, 32'h0);
      chk("rst_serial_out", {24'h0, serial_out}, 32'h0);
      chk("rst_wren", {31'b0, serial_wren_out}, 32'h0);
      chk("rst_rden", {31'b0, serial_rden_out}, 32'h0);
      @(negedge clock);
      serial_valid_in = 1'b0; serial_ready_in = 1'b0;
      reset = 1'b1;

      req(1, 0, 2, ST, 0, 0, 32'h1, "status_init");

      // RAM lanes
      req(0, 1, 2, 32'h1000_0004, 32'h0, 0, 0, "st_w_zero");
      req(0, 1, 0, 32'h1000_0005, 32'hAB, 0, 0, "st_b");
      req(1, 0, 2, 32'h1000_0004, 0, 0, 32'h0000_AB00, "ld_w_after_b");
      req(0, 1, 1, 32'h7fff_0010, 32'hBEEF, 0, 0, "st_h");
      req(1, 0, 0, 32'h7fff_0011, 0, 0, 32'h0000_00BE, "ld_b_hi");
      req(1, 0, 0, 32'h7fff_0010, 0, 0, 32'h0000_00EF, "ld_b_lo");
      req(1, 0, 1, 32'h7fff_0010, 0, 0, 32'h0000_BEEF, "ld_h");
      req(0, 1, 1, 32'h7fff_0012, 32'h1234, 0, 0, "st_h_up");
      req(1, 0, 2, 32'h7fff_0010, 0, 0, 32'h1234_BEEF, "ld_w_stack");
      req(1, 0, 1, 32'h7fff_0012, 0, 0, 32'h0000_1234, "ld_h_up");
      req(0, 1, 2, 32'h1000_0FFC, 32'hCAFE_F00D, 0, 0, "st_last");
      req(1, 0, 2, 32'h1000_0FFC, 0, 0, 32'hCAFE_F00D, "ld_last");

      // faults leave the RAM untouched
      req(1, 0, 2, 32'h1000_0002, 0, 1, 0, "f_misal_w");
      req(1, 0, 2, 32'h2000_0000, 0, 1, 0, "f_unmapped");
      req(1, 1, 2, 32'h1000_0004, 32'hFFFF_FFFF, 1, 0, "f_re_we");
      req(0, 1, 1, 32'h1000_0005, 32'hFFFF, 1, 0, "f_misal_h");
      req(0, 1, 3, 32'h1000_0004, 32'hFFFF_FFFF, 1, 0, "f_size3");
      req(1, 0, 2, 32'h1000_1000, 0, 1, 0, "f_oob");
      req(0, 1, 2, 32'h1000_0006, 32'hFFFF_FFFF, 1, 0, "f_misal_st");
      req(1, 0, 2, 32'h1000_0004, 0, 0, 32'h0000_AB00, "ld_unchanged");

      // serial window direction/offset faults
      req(1, 0, 2, 32'hFFFF_0000, 0, 1, 0, "f_rx_empty");
      req(0, 1, 2, 32'hFFFF_0000, 32'h11, 1, 0, "f_wr_rx");
      req(0, 1, 2, ST, 32'h11, 1, 0, "f_wr_status");
      req(1, 0, 2, 32'hFFFF_0008, 0, 1, 0, "f_rd_tx");
      req(1, 0, 2, 32'hFFFF_000C, 0, 1, 0, "f_bad_off");
      req(1, 0, 3, ST, 0, 1, 0, "f_ser_size3");

      // TX fill to full with link stalled
      for (int i = 0; i < 5; i++)
         req(0, 1, 0, 32'hFFFF_0008, 32'h10 + i, (i == 4), 0, $sformatf("tx_push%0d", i));
      req(1, 0, 0, ST, 0, 0, 32'h0000_0013, "status_tx_full");
      // push to full TX faults even with a drain on the same edge
      req(0, 1, 2, 32'hFFFF_0008, 32'h99, 1, 0, "f_tx_full_drain");
      serial_ready_in = 1'b1;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (serial_wren_out) begin
            chk("tx_byte", {24'h0, serial_out}, 32'h10 + n);
            n++;
         end
         @(negedge clock);
         re_in = 1'b0; we_in = 1'b0;
      end
      chk("tx_pulses", n, 32'd4);
      serial_ready_in = 1'b0;
      req(1, 0, 2, ST, 0, 0, 32'h1, "status_tx_drained");
      idle();

      // RX fill of two bytes
      serial_valid_in = 1'b1; serial_in = 8'h41;
      #1; chk("rden_41", {31'b0, serial_rden_out}, 32'h1);
      @(negedge clock);
      serial_in = 8'h42;
      #1; chk("rden_42", {31'b0, serial_rden_out}, 32'h1);
      @(negedge clock);
      serial_valid_in = 1'b0;
      req(1, 0, 2, ST, 0, 0, 32'h0000_0200, "status_rx2");
      req(1, 0, 0, 32'hFFFF_0000, 0, 0, 32'h41, "rx_pop41");
      req(1, 0, 1, 32'hFFFF_0000, 0, 0, 32'h42, "rx_pop42");
      req(1, 0, 2, 32'hFFFF_0000, 0, 1, 0, "f_rx_pop3");
      idle();

      // RX fill until full: link byte held back once full
      n = 0;
      serial_valid_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         serial_in = 8'h50 + 8'(i);
         #1;
         if (serial_rden_out) n++;
         @(negedge clock);
      end
      serial_valid_in = 1'b0;
      chk("rx_fill_pulses", n, 32'd4);
      req(1, 0, 2, ST, 0, 0, 32'h0000_0400, "status_rx_full");
      for (int i = 0; i < 4; i++)
         req(1, 0, 2, 32'hFFFF_0000, 0, 0, 32'h50 + i, $sformatf("rx_full_pop%0d", i));
      // pop from empty RX faults even if a fill lands on the same edge
      req(1, 0, 2, 32'hFFFF_0000, 0, 1, 0, "f_rx_empty_fill");
      serial_valid_in = 1'b1; serial_in = 8'h77;
      @(negedge clock);
      serial_valid_in = 1'b0; re_in = 1'b0;
      req(1, 0, 2, 32'hFFFF_0000, 0, 0, 32'h77, "rx_pop77");
      idle();

      // partly full FIFOs, then reset with a request on the bus
      serial_valid_in = 1'b1; serial_in = 8'h33;
      @(negedge clock);
      serial_valid_in = 1'b0;
      req(0, 1, 0, 32'hFFFF_0008, 32'h21, 0, 0, "tx_push21");
      req(0, 1, 0, 32'hFFFF_0008, 32'h22, 0, 0, "tx_push22");
      req(1, 0, 2, ST, 0, 0, 32'h0000_0108, "status_partial");
      @(negedge clock);
      re_in = 1'b1; we_in = 1'b0; addr_in = ST;
      reset = 1'b0;
      serial_valid_in = 1'b1; serial_ready_in = 1'b1;
      #1;
      chk("mid_rst_valid", {31'b0, resp_valid_out}, 32'h0);
      chk("mid_rst_wren", {31'b0, serial_wren_out}, 32'h0);
      chk("mid_rst_rden", {31'b0, serial_rden_out}, 32'h0);
      chk("mid_rst_serial_out", {24'h0, serial_out}, 32'h0);
      @(negedge clock);
      re_in = 1'b0; serial_valid_in = 1'b0; serial_ready_in = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      req(1, 0, 2, ST, 0, 0, 32'h1, "status_after_rst");
      idle();
      repeat (3) @(negedge clock);
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
